// File: rtl/lif_output_layer_if.sv
// -----------------------------------------------------------------------------
// lif_output_layer_if
// Bundles the timestep handshake, the spike vectors, the weight-write port and
// the membrane clear of the LIF output layer.
//   master : driven by the hidden layer / host (step request, spikes, weights)
//   slave  : the output layer itself
// Signals:
//   step_valid  request to process one timestep
//   step_ready  layer idle, able to accept a timestep
//   spike_in    N_IN-bit input spike vector
//   spike_out   N_OUT-bit fired-neuron vector, held until the next out_valid
//   out_valid   one-cycle pulse marking a new spike_out
//   w_we/w_addr/w_data  weight table write port (addr = out_idx*N_IN + in_idx)
//   vmem_clear  clear all membranes (honoured while idle)
// -----------------------------------------------------------------------------
interface lif_output_layer_if #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 2,
    parameter int W_BITS = 8,
    parameter int A_BITS = 4
);
    logic              step_valid;
    logic              step_ready;
    logic [N_IN-1:0]   spike_in;
    logic [N_OUT-1:0]  spike_out;
    logic              out_valid;
    logic              w_we;
    logic [A_BITS-1:0] w_addr;
    logic [W_BITS-1:0] w_data;
    logic              vmem_clear;

    modport master (
        output step_valid, spike_in, w_we, w_addr, w_data, vmem_clear,
        input  step_ready, spike_out, out_valid
    );

    modport slave (
        input  step_valid, spike_in, w_we, w_addr, w_data, vmem_clear,
        output step_ready, spike_out, out_valid
    );
endinterface

// File: rtl/lif_output_layer.sv
// -----------------------------------------------------------------------------
// lif_output_layer
// Output layer of N_OUT leaky integrate-and-fire neurons. Each accepted
// timestep walks the latched spike vector one input index per cycle (all
// neurons in parallel), adding saturated signed weights from a writable table,
// then applies leak, thresholds (v > THETA), resets fired membranes and emits
// spike_out with a one-cycle out_valid.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     lif_output_layer_if.slave (handshake, spikes, weight port, clear)
// Optional feature macro: LIF_OUT_REFRACTORY_EN -- per-neuron refractory
// counter loaded with REFRAC_STEPS on firing; while nonzero the neuron is held
// at v=0, skips integration/leak and cannot fire.
// -----------------------------------------------------------------------------
module lif_output_layer #(
    parameter int N_IN         = 8,
    parameter int N_OUT        = 2,
    parameter int W_BITS       = 8,
    parameter int V_BITS       = 12,
    parameter int THETA        = 112,
    parameter int LEAK_SHIFT   = 4,
    parameter int A_BITS       = 4,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    lif_output_layer_if.slave    bus
);
    localparam int N_W      = N_IN * N_OUT;
    localparam int WA_BITS  = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int IDX_BITS = $clog2(N_IN);

    localparam logic [IDX_BITS-1:0]      IDX_LAST = IDX_BITS'(N_IN - 1);
    localparam logic [IDX_BITS-1:0]      IDX_ONE  = IDX_BITS'(1);
    localparam logic [A_BITS:0]          N_W_A    = (A_BITS + 1)'(N_W);
    localparam logic signed [V_BITS-1:0] THETA_V  = V_BITS'(THETA);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_LEAK  = 2'd2;
    localparam logic [1:0] S_FIRE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [IDX_BITS-1:0]       idx_q, idx_d;
    logic [N_IN-1:0]           spk_q, spk_d;
    logic [N_OUT-1:0]          spike_out_q, spike_out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      step_ready_q, step_ready_d;
    logic signed [V_BITS-1:0]  v_q [N_OUT];
    logic signed [V_BITS-1:0]  v_d [N_OUT];
    logic signed [W_BITS-1:0]  w_q [N_W];
    logic [WA_BITS-1:0]        rd_addr_s [N_OUT];
    logic [N_OUT-1:0]          busy_s;
    logic [N_OUT-1:0]          fire_s;
    logic                      w_wr_ok_s;

    // Add a sign-extended weight at V_BITS+1 and clamp to the membrane range.
    function automatic logic signed [V_BITS-1:0] sat_add(
        input logic signed [V_BITS-1:0] a,
        input logic signed [W_BITS-1:0] b
    );
        logic [V_BITS:0] sum;
        sum = {a[V_BITS-1], a} + {{(V_BITS + 1 - W_BITS){b[W_BITS-1]}}, b};
        if (sum[V_BITS] != sum[V_BITS-1]) begin
            // Top two bits disagree: overflow, sign bit tells the direction.
            if (sum[V_BITS]) begin
                return {1'b1, {(V_BITS - 1){1'b0}}};
            end else begin
                return {1'b0, {(V_BITS - 1){1'b1}}};
            end
        end else begin
            return sum[V_BITS-1:0];
        end
    endfunction

    // Leak toward zero by an arithmetic-shift fraction; cannot overflow.
    function automatic logic signed [V_BITS-1:0] leak(input logic signed [V_BITS-1:0] v);
        if (LEAK_SHIFT > 0) begin
            return v - (v >>> LEAK_SHIFT);
        end else begin
            return v;
        end
    endfunction

    assign bus.step_ready = step_ready_q;
    assign bus.spike_out  = spike_out_q;
    assign bus.out_valid  = out_valid_q;

    // Weight-table read address of each neuron for the current input index.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            rd_addr_s[n] = WA_BITS'(n * N_IN) + WA_BITS'(idx_q);
        end
    end

    // Fire decision, only meaningful in FIRE and never for a refractory neuron.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            fire_s[n] = (state_q == S_FIRE) && !busy_s[n] && (v_q[n] > THETA_V);
        end
    end

`ifdef LIF_OUT_REFRACTORY_EN
    localparam int RC_BITS = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
    localparam logic [RC_BITS-1:0] RC_LOAD = RC_BITS'(REFRAC_STEPS);
    localparam logic [RC_BITS-1:0] RC_ONE  = RC_BITS'(1);

    logic [RC_BITS-1:0] rc_q [N_OUT];
    logic [RC_BITS-1:0] rc_d [N_OUT];

    // A neuron is refractory while its counter is nonzero.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            busy_s[n] = (rc_q[n] != {RC_BITS{1'b0}});
        end
    end

    // Counters count FIRE phases: load on firing, decrement while refractory.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            rc_d[n] = rc_q[n];
            case (state_q)
                S_IDLE: begin
                    if (bus.vmem_clear) begin
                        rc_d[n] = {RC_BITS{1'b0}};
                    end else begin
                        rc_d[n] = rc_q[n];
                    end
                end
                S_FIRE: begin
                    if (busy_s[n]) begin
                        rc_d[n] = rc_q[n] - RC_ONE;
                    end else if (fire_s[n]) begin
                        rc_d[n] = RC_LOAD;
                    end else begin
                        rc_d[n] = rc_q[n];
                    end
                end
                default: rc_d[n] = rc_q[n];
            endcase
        end
    end

    // Refractory counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < N_OUT; n++) begin
                rc_q[n] <= {RC_BITS{1'b0}};
            end
        end else begin
            for (int n = 0; n < N_OUT; n++) begin
                rc_q[n] <= rc_d[n];
            end
        end
    end
`else
    // Without the refractory feature no neuron is ever held off.
    always_comb begin
        busy_s = {N_OUT{1'b0}};
    end
`endif

    // Sequencer and membrane update: IDLE -> ACCUM (N_IN cycles) -> LEAK -> FIRE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spk_d       = spk_q;
        spike_out_d = spike_out_q;
        out_valid_d = 1'b0;
        for (int n = 0; n < N_OUT; n++) begin
            v_d[n] = v_q[n];
        end
        case (state_q)
            S_IDLE: begin
                // Clear wins over a simultaneous step request.
                if (bus.vmem_clear) begin
                    for (int n = 0; n < N_OUT; n++) begin
                        v_d[n] = {V_BITS{1'b0}};
                    end
                end else if (bus.step_valid) begin
                    spk_d   = bus.spike_in;
                    idx_d   = {IDX_BITS{1'b0}};
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (busy_s[n]) begin
                        v_d[n] = {V_BITS{1'b0}};
                    end else if (spk_q[idx_q]) begin
                        v_d[n] = sat_add(v_q[n], w_q[rd_addr_s[n]]);
                    end else begin
                        v_d[n] = v_q[n];
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_LEAK;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_LEAK: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (busy_s[n]) begin
                        v_d[n] = {V_BITS{1'b0}};
                    end else begin
                        v_d[n] = leak(v_q[n]);
                    end
                end
                state_d = S_FIRE;
            end
            S_FIRE: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (fire_s[n] || busy_s[n]) begin
                        v_d[n] = {V_BITS{1'b0}};
                    end else begin
                        v_d[n] = v_q[n];
                    end
                end
                spike_out_d = fire_s;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        step_ready_d = (state_d == S_IDLE);
    end

    // Control, output and membrane registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            idx_q        <= {IDX_BITS{1'b0}};
            spk_q        <= {N_IN{1'b0}};
            spike_out_q  <= {N_OUT{1'b0}};
            out_valid_q  <= 1'b0;
            step_ready_q <= 1'b1;
            for (int n = 0; n < N_OUT; n++) begin
                v_q[n] <= {V_BITS{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            spk_q        <= spk_d;
            spike_out_q  <= spike_out_d;
            out_valid_q  <= out_valid_d;
            step_ready_q <= step_ready_d;
            for (int n = 0; n < N_OUT; n++) begin
                v_q[n] <= v_d[n];
            end
        end
    end

    // Writes to out-of-range addresses are dropped.
    assign w_wr_ok_s = bus.w_we && ({1'b0, bus.w_addr} < N_W_A);

    // Weight table; a same-cycle ACCUM read sees the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_W; k++) begin
                w_q[k] <= {W_BITS{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_W; k++) begin
                if (w_wr_ok_s && (bus.w_addr[WA_BITS-1:0] == WA_BITS'(k))) begin
                    w_q[k] <= bus.w_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_output_layer.sv
module tb_lif_output_layer;
    localparam int N_IN = 8, N_OUT = 2, W_BITS = 8, V_BITS = 12;
    localparam int THETA = 112, LEAK_SHIFT = 4, A_BITS = 4, REFRAC_STEPS = 2;
    localparam int STEP_CYC = N_IN + 2;
    localparam int VMAX = (1 << (V_BITS - 1)) - 1;
    localparam int VMIN = -(1 << (V_BITS - 1));
`ifdef LIF_OUT_REFRACTORY_EN
    localparam int TB_REFRAC = REFRAC_STEPS;
`else
    localparam int TB_REFRAC = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    lif_output_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS), .A_BITS(A_BITS)) bus ();

    lif_output_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS), .V_BITS(V_BITS), .THETA(THETA),
        .LEAK_SHIFT(LEAK_SHIFT), .A_BITS(A_BITS), .REFRAC_STEPS(REFRAC_STEPS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        logic [N_OUT-1:0] spk;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy = 0;
    int   ov_count = 0;
    logic [N_OUT-1:0] hold = '0;
    int   mv [N_OUT];
    int   mr [N_OUT];
    int   mw [N_IN*N_OUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference timestep: integrate with clamping, leak, threshold, refractory.
    function automatic logic [N_OUT-1:0] model_step(input logic [N_IN-1:0] s);
        logic [N_OUT-1:0] f;
        f = '0;
        for (int n = 0; n < N_OUT; n++) begin
            if (mr[n] > 0) begin
                mv[n] = 0;
                mr[n] = mr[n] - 1;
            end else begin
                for (int i = 0; i < N_IN; i++) begin
                    if (s[i]) begin
                        mv[n] = mv[n] + mw[n*N_IN + i];
                        if (mv[n] > VMAX) mv[n] = VMAX;
                        if (mv[n] < VMIN) mv[n] = VMIN;
                    end
                end
                if (LEAK_SHIFT > 0) mv[n] = mv[n] - (mv[n] >>> LEAK_SHIFT);
                if (mv[n] > THETA) begin
                    f[n]  = 1'b1;
                    mv[n] = 0;
                    mr[n] = TB_REFRAC;
                end
            end
        end
        return f;
    endfunction

    // Model of the layer's externally visible behaviour, advanced on each edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            busy = 0;
            for (int n = 0; n < N_OUT; n++) begin mv[n] = 0; mr[n] = 0; end
            for (int k = 0; k < N_IN*N_OUT; k++) mw[k] = 0;
        end else begin
            exp_t e;
            cyc = cyc + 1;
            if (bus.w_we && (int'(bus.w_addr) < N_IN*N_OUT))
                mw[bus.w_addr] = int'($signed(bus.w_data));
            if (busy == 0) begin
                if (bus.vmem_clear) begin
                    for (int n = 0; n < N_OUT; n++) begin mv[n] = 0; mr[n] = 0; end
                end else if (bus.step_valid) begin
                    e.spk = model_step(bus.spike_in);
                    e.due = cyc + STEP_CYC;
                    exp_q.push_back(e);
                    busy = STEP_CYC;
                end
            end else begin
                busy = busy - 1;
            end
        end
    end

    // Monitor: compares every DUT output presentation against the scoreboard.
    always @(negedge clk) begin
        if (!resetn) begin
            hold = '0;
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_spike_out", 32'(bus.spike_out), 32'd0);
            check("rst_step_ready", 32'(bus.step_ready), 32'd1);
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("spike_out", 32'(bus.spike_out), 32'(e.spk));
                    check("latency_cycle", 32'(cyc), 32'(e.due));
                    hold = e.spk;
                    ov_count++;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("missing_out_valid", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            check("step_ready", 32'(bus.step_ready), 32'(busy == 0));
            check("spike_out_hold", 32'(bus.spike_out), 32'(hold));
        end
    end

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        bus.w_we = 1'b1; bus.w_addr = A_BITS'(addr); bus.w_data = W_BITS'(data);
        @(negedge clk);
        bus.w_we = 1'b0;
    endtask

    task automatic set_neuron(input int n, input int val);
        for (int i = 0; i < N_IN; i++) wr(n*N_IN + i, val);
    endtask

    task automatic do_step(input logic [N_IN-1:0] s);
        @(negedge clk);
        bus.step_valid = 1'b1; bus.spike_in = s;
        @(negedge clk);
        bus.step_valid = 1'b0;
        repeat (STEP_CYC + 1) @(negedge clk);
    endtask

    task automatic clear_vmem();
        @(negedge clk);
        bus.vmem_clear = 1'b1;
        @(negedge clk);
        bus.vmem_clear = 1'b0;
    endtask

    logic [3:0] refr_seq;
    int         ov_before;

    initial begin
        bus.step_valid = 1'b0; bus.spike_in = '0; bus.w_we = 1'b0;
        bus.w_addr = '0; bus.w_data = '0; bus.vmem_clear = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single step with defaults: neuron 0 fires, neuron 1 keeps 38.
        set_neuron(0, 20);
        set_neuron(1, 5);
        do_step(8'hFF);
        check("scn_single_spike", 32'(bus.spike_out), 32'd1);
        do_step(8'hFF);
        do_step(8'hFF);
        do_step(8'hFF);

        // Reset in the middle of ACCUM aborts the step.
        @(negedge clk);
        bus.step_valid = 1'b1; bus.spike_in = 8'hFF;
        @(negedge clk);
        bus.step_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_no_ov", 32'(bus.out_valid), 32'd0);

        // Negative saturation on neuron 0.
        set_neuron(0, -128);
        set_neuron(1, 5);
        for (int k = 0; k < 3; k++) begin
            do_step(8'hFF);
            check("negsat_no_spike0", 32'(bus.spike_out[0]), 32'd0);
        end
        do_step(8'h01);

        // Clear together with a step request: clear wins, no step accepted.
        @(negedge clk);
        bus.vmem_clear = 1'b1; bus.step_valid = 1'b1; bus.spike_in = 8'hFF;
        @(negedge clk);
        bus.vmem_clear = 1'b0; bus.step_valid = 1'b0;
        check("clear_blocks_step", 32'(bus.step_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("clear_no_ov", 32'(bus.out_valid), 32'd0);
        do_step(8'hF0);

        // step_valid held high: one accept every STEP_CYC+1 cycles.
        for (int k = 0; k < N_IN*N_OUT; k++) wr(k, int'($urandom_range(0, 60)) - 20);
        ov_before = ov_count;
        @(negedge clk);
        bus.step_valid = 1'b1;
        for (int c = 0; c < 5*(STEP_CYC + 1); c++) begin
            bus.spike_in = N_IN'($urandom);
            @(negedge clk);
        end
        bus.step_valid = 1'b0;
        repeat (STEP_CYC + 2) @(negedge clk);
        check("held_valid_steps", 32'(ov_count - ov_before), 32'd5);

        // Refractory behaviour (or plain re-firing) on the single-step stimulus.
        clear_vmem();
        set_neuron(0, 20);
        set_neuron(1, 5);
        for (int k = 0; k < 4; k++) begin
            do_step(8'hFF);
            refr_seq[3-k] = bus.spike_out[0];
        end
`ifdef LIF_OUT_REFRACTORY_EN
        check("refrac_sequence", 32'(refr_seq), 32'(4'b1001));
`else
        check("refire_sequence", 32'(refr_seq), 32'(4'b1111));
`endif

        // Randomized mix of weight writes, clears and steps.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                for (int k = 0; k < 3; k++) wr($urandom_range(0, N_IN*N_OUT - 1), $urandom_range(0, 255));
            end else if (r == 3) begin
                clear_vmem();
            end else begin
                do_step(N_IN'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        repeat (STEP_CYC + 4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lif_output_layer.md
Name: lif_output_layer

Overview:
- Parametrised output layer of leaky integrate-and-fire neurons for the ECG spiking classifier; successor to the single-neuron, single-weight output stage.
- Each timestep it accepts one N_IN-bit spike vector from the hidden layer and integrates signed per-synapse weights into N_OUT membrane potentials, one input index per cycle with all neurons in parallel.
- It then applies leak, thresholds the membranes, and emits an N_OUT spike vector with a valid pulse.
- Weights are held in a writable on-chip table, not in a fixed ROM.

Parameters:
- N_IN, 8, input spike lines (synapses per neuron), >=2
- N_OUT, 2, output neurons
- W_BITS, 8, signed weight width
- V_BITS, 12, signed membrane width
- THETA, 112, firing threshold; signed and strictly compared (v > THETA)
- LEAK_SHIFT, 4, leak v -= v>>>LEAK_SHIFT; 0 disables leak
- A_BITS, 4, weight address width, >= clog2(N_IN*N_OUT)
- REFRAC_STEPS, 2, refractory length in timesteps (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- step_valid  in  1  request to process one timestep
- step_ready  out  1  high when idle and able to accept a timestep
- spike_in  in  N_IN  input spike vector; sampled on the accept edge
- spike_out  out  N_OUT  fired neurons; held until the next out_valid
- out_valid  out  1  one-cycle pulse marking a new spike_out
- w_we  in  1  weight write enable
- w_addr  in  A_BITS  weight address = out_idx*N_IN + in_idx
- w_data  in  W_BITS  signed weight
- vmem_clear  in  1  synchronous clear of all membranes (honoured only in IDLE)

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM goes to IDLE.
  - All membranes, weights, spike_out, out_valid and the index counter go to 0; step_ready=1.
  - Reset mid-timestep aborts the step: no out_valid is produced.
- FSM states: IDLE, ACCUM, LEAK, FIRE. step_ready = (state==IDLE).
- IDLE:
  - vmem_clear=1 zeroes all membranes; this takes priority, so no step is accepted in that cycle.
  - Otherwise step_valid=1 latches spike_in, sets idx=0, and moves to ACCUM.
- ACCUM:
  - One cycle per idx, 0..N_IN-1.
  - For every neuron n with latched bit idx set: v[n] = sat(v[n] + sext(w[n*N_IN+idx])).
  - After idx=N_IN-1, move to LEAK.
- LEAK:
  - One cycle: v[n] = v[n] - (v[n]>>>LEAK_SHIFT), arithmetic shift.
  - Skipped (held unchanged) when LEAK_SHIFT=0; the cycle still elapses.
- FIRE:
  - One cycle: fire[n] = (v[n] > THETA). Fired membranes reset to 0; spike_out <= fire; out_valid <= 1.
  - Move to IDLE.
- Latency: out_valid is high in the cycle following the (N_IN+2)th edge after the accept edge. The next step can be accepted in that same cycle.
- step_valid while busy is ignored; there is no queueing.
- Saturation:
  - Each addition is computed at V_BITS+1 and clamped to [-2^(V_BITS-1), 2^(V_BITS-1)-1].
  - Leak cannot overflow.
- Weight writes:
  - Accepted in any state.
  - A write to the address being read in the same ACCUM cycle: the read returns the old value and the new value is used from the next access.
  - w_addr >= N_IN*N_OUT is ignored.
- spike_in and vmem_clear outside IDLE are don't-care.

Optional Feature:
- Macro: LIF_OUT_REFRACTORY_EN.
- Defined:
  - Each neuron has a counter loaded with REFRAC_STEPS when it fires; the counter decrements once per FIRE phase.
  - While the counter is nonzero the neuron skips ACCUM additions and leak, holds v=0, and cannot fire.
  - Reset and vmem_clear zero the counters.
- Undefined: no counters; a fired neuron integrates from the next timestep.

Test Plan:
- Reset: assert resetn=0 mid-ACCUM, release -> spike_out=0, out_valid=0, step_ready=1, and no out_valid follows.
- Single step, defaults: weights of neuron 0 = 20, neuron 1 = 5, spike_in=8'hFF -> v0=160, after leak 150 > 112, v1=40 after leak 38 -> out_valid 10 edges after accept, spike_out=2'b01, v0=0, v1=38.
- Negative saturation: neuron 0 weights = -128, three steps of 8'hFF -> v0 sequence after each step -960, -1860, then the accumulation clamps at -2048 and leak gives -1920; no spikes.
- Handshake: step_valid held at 1 continuously -> steps accepted every 11 cycles, step_ready low for 10 cycles each, exactly one out_valid per step.
- vmem_clear plus step_valid asserted together in IDLE -> membranes 0, step not accepted, step_ready stays 1.
- LIF_OUT_REFRACTORY_EN with REFRAC_STEPS=2: the scenario-2 stimulus repeated 4 times -> neuron 0 spike_out bits 1,0,0,1.
